// File: rtl/eq_fir_mac.sv
// Single-MAC FIR engine: circular sample delay line, one tap product per cycle
// against a combinationally read coefficient RAM, rounded and saturated output
// over a valid/ready handshake.
module eq_fir_mac #(
  parameter int unsigned TAPS       = 279,
  parameter int unsigned WIDTH      = 16,
  parameter int unsigned ADDR_WIDTH = 16,
  parameter int unsigned FRAC       = 15,
  parameter int unsigned ACC_WIDTH  = 41
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         in_valid,
  input  logic signed [WIDTH-1:0]      in_sample,
  output logic                         in_ready,
  output logic        [ADDR_WIDTH-1:0] coef_addr,
  input  logic signed [WIDTH-1:0]      coef_data,
  output logic                         busy,
  output logic                         out_valid,
  output logic signed [WIDTH-1:0]      out_sample,
  input  logic                         out_ready
);

  localparam int unsigned PtrW = $clog2(TAPS);
  localparam logic signed [ACC_WIDTH-1:0] RndHalf = ACC_WIDTH'(1) <<< (FRAC - 1);
  localparam logic signed [ACC_WIDTH-1:0] SatMax  = (ACC_WIDTH'(1) <<< (WIDTH - 1)) - 1;
  localparam logic signed [ACC_WIDTH-1:0] SatMin  = ~SatMax;

  typedef enum logic [1:0] {StIdle, StMac, StDrain, StOut} state_e;

  state_e state_q, state_d;

  logic signed [WIDTH-1:0]     dline_q [TAPS];
  logic        [PtrW-1:0]      wr_ptr_q, rd_ptr_q, k_q;
  logic signed [2*WIDTH-1:0]   prod_q;
  logic                        prod_vld_q;
  logic signed [ACC_WIDTH-1:0] acc_q;
  logic signed [WIDTH-1:0]     out_sample_q;

  logic signed [WIDTH-1:0]     tap_sample;
  logic signed [2*WIDTH-1:0]   prod_full;
  logic signed [ACC_WIDTH-1:0] prod_ext, acc_fin, acc_shift;
  logic signed [WIDTH-1:0]     sat_val;
  logic        [PtrW-1:0]      rd_ptr_dec, wr_ptr_inc;

  assign tap_sample = dline_q[rd_ptr_q];
  assign prod_full  = (2 * WIDTH)'(coef_data) * (2 * WIDTH)'(tap_sample);
  assign prod_ext   = ACC_WIDTH'(prod_q);
  assign acc_fin    = acc_q + prod_ext;
  // Round half up, then arithmetic shift down to the output scale.
  assign acc_shift  = (acc_fin + RndHalf) >>> FRAC;
  assign rd_ptr_dec = (rd_ptr_q == '0) ? PtrW'(TAPS - 1) : rd_ptr_q - 1'b1;
  assign wr_ptr_inc = (wr_ptr_q == PtrW'(TAPS - 1)) ? '0 : wr_ptr_q + 1'b1;

  // Clamp the shifted accumulator into the output range.
  always_comb begin
    sat_val = acc_shift[WIDTH-1:0];
    if (acc_shift > SatMax) begin
      sat_val = SatMax[WIDTH-1:0];
    end else if (acc_shift < SatMin) begin
      sat_val = SatMin[WIDTH-1:0];
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle:  if (in_valid) state_d = StMac;
      StMac:   if (k_q == PtrW'(TAPS - 1)) state_d = StDrain;
      StDrain: state_d = StOut;
      StOut:   if (out_ready) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Delay line, pointers, MAC pipeline and output register.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < int'(TAPS); i++) begin
        dline_q[i] <= '0;
      end
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      k_q          <= '0;
      prod_q       <= '0;
      prod_vld_q   <= 1'b0;
      acc_q        <= '0;
      out_sample_q <= '0;
    end else begin
      case (state_q)
        StIdle: begin
          if (in_valid) begin
            dline_q[wr_ptr_q] <= in_sample;
            rd_ptr_q          <= wr_ptr_q;
            k_q               <= '0;
            acc_q             <= '0;
            prod_vld_q        <= 1'b0;
          end
        end
        StMac: begin
          prod_q     <= prod_full;
          prod_vld_q <= 1'b1;
          if (prod_vld_q) acc_q <= acc_fin;
          k_q        <= (k_q == PtrW'(TAPS - 1)) ? '0 : k_q + 1'b1;
          rd_ptr_q   <= rd_ptr_dec;
        end
        StDrain: begin
          acc_q        <= acc_fin;
          out_sample_q <= sat_val;
        end
        StOut: begin
          if (out_ready) wr_ptr_q <= wr_ptr_inc;
        end
        default: ;
      endcase
    end
  end

  assign in_ready   = (state_q == StIdle);
  assign busy       = (state_q != StIdle);
  assign out_valid  = (state_q == StOut);
  assign out_sample = out_sample_q;
  assign coef_addr  = (state_q == StMac) ? ADDR_WIDTH'(k_q) : '0;

endmodule

// File: tb/tb_eq_fir_mac.sv
// Scoreboard bench for eq_fir_mac at a reduced filter length; expected outputs
// come from a direct convolution over the accepted-sample history.
module tb_eq_fir_mac;

  localparam int T      = 23;
  localparam int W      = 16;
  localparam int AW     = 16;
  localparam int FR     = 15;
  localparam int ACCW   = 2 * W + $clog2(T);
  localparam int Budget = 5000;

  logic                 clk, rst;
  logic                 in_valid, in_ready;
  logic        [W-1:0]  in_sample;
  logic        [AW-1:0] coef_addr;
  logic signed [W-1:0]  coef_data;
  logic                 busy, out_valid, out_ready;
  logic        [W-1:0]  out_sample;

  logic signed [W-1:0]  coef_mem [T];
  logic                 hold, bp_ready, rnd_ready, rdy_mode;

  longint               hist [$];
  logic        [W-1:0]  exp_q [$];
  int                   checks = 0;
  int                   errors = 0;

  eq_fir_mac #(
    .TAPS      (T),
    .WIDTH     (W),
    .ADDR_WIDTH(AW),
    .FRAC      (FR),
    .ACC_WIDTH (ACCW)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_sample (in_sample),
    .in_ready  (in_ready),
    .coef_addr (coef_addr),
    .coef_data (coef_data),
    .busy      (busy),
    .out_valid (out_valid),
    .out_sample(out_sample),
    .out_ready (out_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign coef_data = (int'(coef_addr) < T) ? coef_mem[int'(coef_addr)] : '0;
  assign out_ready = hold ? bp_ready : rnd_ready;

  initial begin
    rnd_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      rnd_ready = rdy_mode ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic timeout_fail(input string name);
    checks++;
    errors++;
    $display("FAIL %s timeout actual=waiting required=done", name);
  endtask

  // y[n] = sat(round(sum_k coef[k] * x[n-k])) with missing history read as 0.
  function automatic logic [W-1:0] model_out();
    longint acc = 0;
    int     n   = hist.size();
    for (int k = 0; k < T && k < n; k++) begin
      acc += longint'(coef_mem[k]) * hist[n-1-k];
    end
    acc = (acc + 16384) >>> FR;
    if (acc > 32767) return 16'h7fff;
    if (acc < -32768) return 16'h8000;
    return acc[W-1:0];
  endfunction

  task automatic set_all(input logic [W-1:0] v);
    for (int k = 0; k < T; k++) coef_mem[k] = v;
  endtask

  task automatic send(input logic [W-1:0] x);
    int n = 0;
    while (in_ready !== 1'b1) begin
      @(posedge clk);
      #1;
      n++;
      if (n > Budget) begin
        timeout_fail("in_ready_wait");
        return;
      end
    end
    in_valid  = 1'b1;
    in_sample = x;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    hist.push_back(longint'($signed(x)));
    if (hist.size() > T) void'(hist.pop_front());
    exp_q.push_back(model_out());
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((exp_q.size() != 0 || in_ready !== 1'b1) && n < Budget) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (n >= Budget) timeout_fail("drain_wait");
  endtask

  // Monitor: a transfer happens on the next rising edge; compare it here.
  always @(negedge clk) begin
    if (!rst && out_valid === 1'b1 && out_ready === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL out_unexpected actual=%0h required=none", out_sample);
      end else begin
        chk("out_sample", 32'(out_sample), 32'(exp_q.pop_front()));
      end
    end
  end

  initial begin
    int n;
    rst = 1'b1; in_valid = 1'b0; in_sample = '0;
    hold = 1'b0; bp_ready = 1'b0; rdy_mode = 1'b0;
    set_all('0);
    repeat (3) @(posedge clk);
    #1;
    chk("rst_in_ready", 32'(in_ready), 1);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_out_sample", 32'(out_sample), 0);
    chk("rst_coef_addr", 32'(coef_addr), 0);
    rst = 1'b0;

    // Impulse through flat 0.5 coefficients.
    set_all(16'h4000);
    send(16'h7fff);
    repeat (T) send('0);
    wait_idle();

    // Pure delay of T-1 over three laps of the circular buffer.
    for (int k = 0; k < T; k++) coef_mem[k] = (k == T - 1) ? 16'sh7fff : 16'sh0000;
    for (int i = 1; i <= 3 * T; i++) send(16'(i));
    wait_idle();

    // Saturation both ways, with random output backpressure.
    rdy_mode = 1'b1;
    set_all(16'h7fff);
    repeat (T) send(16'h7fff);
    repeat (T) send(16'h8000);
    wait_idle();

    // Random coefficients and samples.
    for (int k = 0; k < T; k++) coef_mem[k] = 16'($urandom);
    repeat (40) send(16'($urandom));
    wait_idle();
    rdy_mode = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    // Latency, address walk, and in_valid ignored while busy.
    send(16'($urandom));
    for (int j = 0; j < T; j++) begin
      chk("mac_coef_addr", 32'(coef_addr), 32'(j));
      chk("mac_in_ready", 32'(in_ready), 0);
      in_valid  = (j == T / 2);
      in_sample = 16'h1234;
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    chk("drain_out_valid", 32'(out_valid), 0);
    chk("drain_coef_addr", 32'(coef_addr), 0);
    @(posedge clk);
    #1;
    chk("latency_out_valid", 32'(out_valid), 1);
    wait_idle();

    // Backpressure hold for 10 cycles.
    bp_ready = 1'b0;
    hold     = 1'b1;
    send(16'($urandom));
    n = 0;
    while (out_valid !== 1'b1 && n < Budget) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (n >= Budget) timeout_fail("bp_out_valid");
    for (int i = 0; i < 10; i++) begin
      chk("bp_out_valid", 32'(out_valid), 1);
      if (exp_q.size() != 0) chk("bp_out_sample", 32'(out_sample), 32'(exp_q[0]));
      else timeout_fail("bp_expect");
      chk("bp_in_ready", 32'(in_ready), 0);
      chk("bp_busy", 32'(busy), 1);
      @(posedge clk);
      #1;
    end
    bp_ready = 1'b1;
    @(posedge clk);
    #1;
    chk("bp_release_out_valid", 32'(out_valid), 0);
    chk("bp_release_in_ready", 32'(in_ready), 1);
    hold = 1'b0;
    wait_idle();

    // Reset in the middle of MAC, then a clean impulse.
    send(16'h5555);
    repeat (T / 2) @(posedge clk);
    #1;
    chk("pre_rst_coef_addr", 32'(coef_addr), 32'(T / 2));
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("mid_rst_out_valid", 32'(out_valid), 0);
    chk("mid_rst_in_ready", 32'(in_ready), 1);
    chk("mid_rst_coef_addr", 32'(coef_addr), 0);
    chk("mid_rst_busy", 32'(busy), 0);
    rst = 1'b0;
    hist.delete();
    exp_q.delete();
    set_all(16'h4000);
    send(16'h7fff);
    repeat (T) send('0);
    wait_idle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
